load_store_queue: RTL and testbench

- In-order load/store queue between the decoder/ROB and the memory controller.
- Accepts memory ops at dispatch and snoops the ALU CDB for base/store-data operands.
- Executes loads speculatively at the queue head; broadcasts results on the LS CDB.
- Writes stores to memory only after the ROB reports them committed; survives misbranch flush with committed stores intact.

---
 rtl/load_store_queue_pkg.sv | 29 ++
 rtl/load_store_queue_load_extend.sv | 20 ++
 rtl/load_store_queue.sv | 213 +++++++++++++++++++++
 tb/tb_load_store_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_queue_pkg.sv
// Shared constants for the load/store queue: default widths, RISC-V funct3
// load/store encodings, memory size codes and the sequencer state type.
package load_store_queue_pkg;
    localparam int LSQ_SIZE_DEF  = 16;
    localparam int ROB_TAG_W_DEF = 4;
    localparam int DATA_W_DEF    = 32;

    localparam logic [ROB_TAG_W_DEF-1:0] ZERO_ROB = '0;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {ST_IDLE, ST_WAIT} lsq_state_t;

    function automatic logic [1:0] mem_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SIZE_B;
            F3_H, F3_HU: return SIZE_H;
            default:     return SIZE_W;
        endcase
    endfunction
endpackage

// File: rtl/load_store_queue_load_extend.sv
// Combinational load-result formatting: byte/half sign or zero extension, word pass-through.
module lsq_load_extend
    import load_store_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] value
);
    always_comb begin
        case (funct3)
            F3_B:    value = {{(DATA_W-8){rdata[7]}}, rdata[7:0]};
            F3_H:    value = {{(DATA_W-16){rdata[15]}}, rdata[15:0]};
            F3_BU:   value = {{(DATA_W-8){1'b0}}, rdata[7:0]};
            F3_HU:   value = {{(DATA_W-16){1'b0}}, rdata[15:0]};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue: CDB operand snooping, speculative head loads, commit-gated stores.
// Optional LSQ_ENQ_BYPASS_EN lets a dispatching op catch a broadcast happening in its enqueue cycle.
module load_store_queue
    import load_store_queue_pkg::*;
#(
    parameter int LSQ_SIZE  = LSQ_SIZE_DEF,
    parameter int ROB_TAG_W = ROB_TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 in_enq_ena,
    input  logic                 in_enq_is_store,
    input  logic [2:0]           in_enq_funct3,
    input  logic [DATA_W-1:0]    in_enq_imm,
    input  logic [ROB_TAG_W-1:0] in_enq_base_tag,
    input  logic [DATA_W-1:0]    in_enq_base_value,
    input  logic [ROB_TAG_W-1:0] in_enq_data_tag,
    input  logic [DATA_W-1:0]    in_enq_data_value,
    input  logic [ROB_TAG_W-1:0] in_enq_rob_tag,
    input  logic [ROB_TAG_W-1:0] in_cdb_rob_tag,
    input  logic [DATA_W-1:0]    in_cdb_value,
    input  logic [ROB_TAG_W-1:0] in_committed_rob_tag,
    input  logic                 in_misbranch,
    output logic                 out_lsq_full,
    output logic                 out_mem_req,
    output logic                 out_mem_we,
    output logic [DATA_W-1:0]    out_mem_addr,
    output logic [DATA_W-1:0]    out_mem_wdata,
    output logic [1:0]           out_mem_size,
    input  logic                 in_mem_done,
    input  logic [DATA_W-1:0]    in_mem_rdata,
    output logic [ROB_TAG_W-1:0] out_ls_cdb_rob_tag,
    output logic [DATA_W-1:0]    out_ls_cdb_value
);
    localparam int PTR_W = $clog2(LSQ_SIZE);
    localparam int CNT_W = PTR_W + 1;

    logic [LSQ_SIZE-1:0]  valid, is_store, announced, committed, commit_now;
    logic [2:0]           funct3     [LSQ_SIZE];
    logic [DATA_W-1:0]    imm        [LSQ_SIZE];
    logic [DATA_W-1:0]    base_value [LSQ_SIZE];
    logic [DATA_W-1:0]    data_value [LSQ_SIZE];
    logic [ROB_TAG_W-1:0] rob_tag    [LSQ_SIZE];
    logic [ROB_TAG_W-1:0] base_tag   [LSQ_SIZE];
    logic [ROB_TAG_W-1:0] data_tag   [LSQ_SIZE];

    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     count, commit_count;
    lsq_state_t           state;
    logic                 wait_load, wait_discard;
    logic                 enq, deq, deq_kept, head_ready;
    logic [ROB_TAG_W-1:0] enq_base_tag, enq_data_tag;
    logic [DATA_W-1:0]    enq_base_value, enq_data_value, load_value;

    assign out_lsq_full = (count == CNT_W'(LSQ_SIZE));
    assign enq          = ena && in_enq_ena && !out_lsq_full && !in_misbranch;
    // A load orphaned by a misbranch was already removed from the queue when flushed.
    assign deq          = ena && (state == ST_WAIT) && in_mem_done && !wait_discard;
    assign deq_kept     = deq && commit_now[head];
    assign head_ready   = (base_tag[head] == '0) && (!is_store[head] || data_tag[head] == '0);

    always_comb begin
        commit_now   = '0;
        commit_count = '0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            commit_now[i] = valid[i] && is_store[i] && (committed[i] ||
                            (in_committed_rob_tag != '0 && rob_tag[i] == in_committed_rob_tag));
            commit_count  = commit_count + CNT_W'(commit_now[i]);
        end
    end

`ifdef LSQ_ENQ_BYPASS_EN
    function automatic logic [ROB_TAG_W+DATA_W-1:0] bypass(
        input logic [ROB_TAG_W-1:0] tag,     input logic [DATA_W-1:0] value,
        input logic [ROB_TAG_W-1:0] cdb_tag, input logic [DATA_W-1:0] cdb_value,
        input logic [ROB_TAG_W-1:0] ls_tag,  input logic [DATA_W-1:0] ls_value);
        if (tag != '0 && tag == cdb_tag) return {{ROB_TAG_W{1'b0}}, cdb_value};
        if (tag != '0 && tag == ls_tag)  return {{ROB_TAG_W{1'b0}}, ls_value};
        return {tag, value};
    endfunction

    assign {enq_base_tag, enq_base_value} = bypass(in_enq_base_tag, in_enq_base_value,
        in_cdb_rob_tag, in_cdb_value, out_ls_cdb_rob_tag, out_ls_cdb_value);
    assign {enq_data_tag, enq_data_value} = bypass(in_enq_data_tag, in_enq_data_value,
        in_cdb_rob_tag, in_cdb_value, out_ls_cdb_rob_tag, out_ls_cdb_value);
`else
    assign {enq_base_tag, enq_base_value} = {in_enq_base_tag, in_enq_base_value};
    assign {enq_data_tag, enq_data_value} = {in_enq_data_tag, in_enq_data_value};
`endif

    lsq_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .funct3 (funct3[head]),
        .rdata  (in_mem_rdata),
        .value  (load_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            state        <= ST_IDLE;
            wait_load    <= 1'b0;
            wait_discard <= 1'b0;
            valid        <= '0;
            is_store     <= '0;
            announced    <= '0;
            committed    <= '0;
            for (int i = 0; i < LSQ_SIZE; i++) begin
                funct3[i]     <= '0;
                imm[i]        <= '0;
                rob_tag[i]    <= '0;
                base_tag[i]   <= '0;
                base_value[i] <= '0;
                data_tag[i]   <= '0;
                data_value[i] <= '0;
            end
            out_mem_req        <= 1'b0;
            out_mem_we         <= 1'b0;
            out_mem_addr       <= '0;
            out_mem_wdata      <= '0;
            out_mem_size       <= '0;
            out_ls_cdb_rob_tag <= '0;
            out_ls_cdb_value   <= '0;
        end else if (ena) begin
            out_ls_cdb_rob_tag <= '0;
            out_ls_cdb_value   <= '0;

            for (int i = 0; i < LSQ_SIZE; i++) begin
                if (valid[i] && base_tag[i] != '0) begin
                    if (base_tag[i] == in_cdb_rob_tag) begin
                        base_tag[i] <= '0; base_value[i] <= in_cdb_value;
                    end else if (base_tag[i] == out_ls_cdb_rob_tag) begin
                        base_tag[i] <= '0; base_value[i] <= out_ls_cdb_value;
                    end
                end
                if (valid[i] && data_tag[i] != '0) begin
                    if (data_tag[i] == in_cdb_rob_tag) begin
                        data_tag[i] <= '0; data_value[i] <= in_cdb_value;
                    end else if (data_tag[i] == out_ls_cdb_rob_tag) begin
                        data_tag[i] <= '0; data_value[i] <= out_ls_cdb_value;
                    end
                end
                if (commit_now[i]) committed[i] <= 1'b1;
            end

            if (enq) begin
                valid[tail]      <= 1'b1;
                is_store[tail]   <= in_enq_is_store;
                funct3[tail]     <= in_enq_funct3;
                imm[tail]        <= in_enq_imm;
                rob_tag[tail]    <= in_enq_rob_tag;
                base_tag[tail]   <= enq_base_tag;
                base_value[tail] <= enq_base_value;
                data_tag[tail]   <= enq_data_tag;
                data_value[tail] <= enq_data_value;
                announced[tail]  <= 1'b0;
                committed[tail]  <= 1'b0;
            end

            case (state)
                ST_IDLE: if (valid[head] && head_ready && !in_misbranch) begin
                    if (!is_store[head] || commit_now[head]) begin
                        state         <= ST_WAIT;
                        wait_load     <= !is_store[head];
                        wait_discard  <= 1'b0;
                        out_mem_req   <= 1'b1;
                        out_mem_we    <= is_store[head];
                        out_mem_addr  <= base_value[head] + imm[head];
                        out_mem_wdata <= is_store[head] ? data_value[head] : '0;
                        out_mem_size  <= mem_size(funct3[head]);
                    end else if (!announced[head]) begin
                        announced[head]    <= 1'b1;
                        out_ls_cdb_rob_tag <= rob_tag[head];
                    end
                end
                ST_WAIT: if (in_mem_done) begin
                    state         <= ST_IDLE;
                    wait_discard  <= 1'b0;
                    out_mem_req   <= 1'b0;
                    out_mem_we    <= 1'b0;
                    out_mem_addr  <= '0;
                    out_mem_wdata <= '0;
                    out_mem_size  <= '0;
                    if (wait_load && !wait_discard && !in_misbranch) begin
                        out_ls_cdb_rob_tag <= rob_tag[head];
                        out_ls_cdb_value   <= load_value;
                    end
                end else if (in_misbranch && wait_load) begin
                    wait_discard <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            if (deq) valid[head] <= 1'b0;

            // Committed stores always sit at the head, so a flush just truncates the queue.
            if (in_misbranch) begin
                for (int i = 0; i < LSQ_SIZE; i++)
                    if (!commit_now[i]) valid[i] <= 1'b0;
                head  <= head + PTR_W'(deq_kept);
                tail  <= head + commit_count[PTR_W-1:0];
                count <= commit_count - CNT_W'(deq_kept);
            end else begin
                head  <= head + PTR_W'(deq);
                tail  <= tail + PTR_W'(enq);
                count <= count + CNT_W'(enq) - CNT_W'(deq);
            end
        end
    end
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: hand-computed vectors checked by immediate assertions.
module tb_load_store_queue;
    import load_store_queue_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic        in_enq_ena = 1'b0, in_enq_is_store = 1'b0;
    logic [2:0]  in_enq_funct3 = '0;
    logic [31:0] in_enq_imm = '0, in_enq_base_value = '0, in_enq_data_value = '0;
    logic [3:0]  in_enq_base_tag = '0, in_enq_data_tag = '0, in_enq_rob_tag = '0;
    logic [3:0]  in_cdb_rob_tag = '0, in_committed_rob_tag = '0;
    logic [31:0] in_cdb_value = '0, in_mem_rdata = '0;
    logic        in_misbranch = 1'b0, in_mem_done = 1'b0;
    logic        out_lsq_full, out_mem_req, out_mem_we;
    logic [31:0] out_mem_addr, out_mem_wdata, out_ls_cdb_value;
    logic [1:0]  out_mem_size;
    logic [3:0]  out_ls_cdb_rob_tag;

    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    load_store_queue dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_enq_ena(in_enq_ena), .in_enq_is_store(in_enq_is_store),
        .in_enq_funct3(in_enq_funct3), .in_enq_imm(in_enq_imm),
        .in_enq_base_tag(in_enq_base_tag), .in_enq_base_value(in_enq_base_value),
        .in_enq_data_tag(in_enq_data_tag), .in_enq_data_value(in_enq_data_value),
        .in_enq_rob_tag(in_enq_rob_tag),
        .in_cdb_rob_tag(in_cdb_rob_tag), .in_cdb_value(in_cdb_value),
        .in_committed_rob_tag(in_committed_rob_tag), .in_misbranch(in_misbranch),
        .out_lsq_full(out_lsq_full),
        .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
        .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
        .out_mem_size(out_mem_size),
        .in_mem_done(in_mem_done), .in_mem_rdata(in_mem_rdata),
        .out_ls_cdb_rob_tag(out_ls_cdb_rob_tag), .out_ls_cdb_value(out_ls_cdb_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [3:0] bt, input logic [31:0] bv,
                       input logic [3:0] dt, input logic [31:0] dv, input logic [3:0] rt);
        in_enq_ena = 1'b1; in_enq_is_store = st; in_enq_funct3 = f3; in_enq_imm = imm;
        in_enq_base_tag = bt; in_enq_base_value = bv;
        in_enq_data_tag = dt; in_enq_data_value = dv; in_enq_rob_tag = rt;
        tick();
        in_enq_ena = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!out_mem_req && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_mem_req), 32'd1);
    endtask

    task automatic mem_done(input logic [31:0] rd);
        in_mem_done = 1'b1; in_mem_rdata = rd;
        tick();
        in_mem_done = 1'b0; in_mem_rdata = '0;
    endtask

    initial begin
        int hits;
        // reset
        tick(); tick();
        chk("rst_req", 32'(out_mem_req), 32'd0);
        chk("rst_full", 32'(out_lsq_full), 32'd0);
        chk("rst_cdb_tag", 32'(out_ls_cdb_rob_tag), 32'd0);
        chk("rst_addr", out_mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // LB from 0x100+4, memory returns 0x80 after 3 cycles
        enq(1'b0, F3_B, 32'd4, 4'd0, 32'h100, 4'd0, 32'd0, 4'd1);
        tick();
        chk("lb_req", 32'(out_mem_req), 32'd1);
        chk("lb_we", 32'(out_mem_we), 32'd0);
        chk("lb_addr", out_mem_addr, 32'h104);
        chk("lb_size", 32'(out_mem_size), 32'd0);
        tick(); tick();
        chk("lb_hold_req", 32'(out_mem_req), 32'd1);
        chk("lb_hold_addr", out_mem_addr, 32'h104);
        mem_done(32'h80);
        chk("lb_cdb_tag", 32'(out_ls_cdb_rob_tag), 32'd1);
        chk("lb_cdb_val", out_ls_cdb_value, 32'hFFFF_FF80);
        chk("lb_req_drop", 32'(out_mem_req), 32'd0);
        tick();
        chk("lb_cdb_pulse", 32'(out_ls_cdb_rob_tag), 32'd0);

        // store waiting on data tag 3, announced, then written only after commit
        enq(1'b1, F3_W, 32'd0, 4'd0, 32'h200, 4'd3, 32'd0, 4'd2);
        in_cdb_rob_tag = 4'd3; in_cdb_value = 32'hDEAD_BEEF;
        tick();
        in_cdb_rob_tag = 4'd0; in_cdb_value = '0;
        tick();
        chk("st_announce_tag", 32'(out_ls_cdb_rob_tag), 32'd2);
        chk("st_announce_val", out_ls_cdb_value, 32'd0);
        chk("st_no_early_req", 32'(out_mem_req), 32'd0);
        tick();
        chk("st_announce_once", 32'(out_ls_cdb_rob_tag), 32'd0);
        tick(); tick();
        chk("st_wait_commit", 32'(out_mem_req), 32'd0);
        in_committed_rob_tag = 4'd2;
        tick();
        in_committed_rob_tag = 4'd0;
        chk("st_req", 32'(out_mem_req), 32'd1);
        chk("st_we", 32'(out_mem_we), 32'd1);
        chk("st_addr", out_mem_addr, 32'h200);
        chk("st_wdata", out_mem_wdata, 32'hDEAD_BEEF);
        chk("st_size", 32'(out_mem_size), 32'd2);
        mem_done(32'd0);
        chk("st_no_bcast", 32'(out_ls_cdb_rob_tag), 32'd0);
        chk("st_req_drop", 32'(out_mem_req), 32'd0);

        // fill to 16 with loads blocked on base tag 7; 17th ignored
        for (int i = 0; i < 16; i++) begin
            enq(1'b0, F3_W, 32'(i * 4), 4'd7, 32'd0, 4'd0, 32'd0, 4'((i % 15) + 1));
            if (i == 14) chk("fill_not_full", 32'(out_lsq_full), 32'd0);
        end
        chk("fill_full", 32'(out_lsq_full), 32'd1);
        enq(1'b0, F3_W, 32'd0, 4'd0, 32'hBAD, 4'd0, 32'd0, 4'd9);
        chk("fill_17th_full", 32'(out_lsq_full), 32'd1);
        chk("fill_blocked", 32'(out_mem_req), 32'd0);
        in_cdb_rob_tag = 4'd7; in_cdb_value = 32'h1000;
        tick();
        in_cdb_rob_tag = 4'd0; in_cdb_value = '0;
        for (int k = 0; k < 16; k++) begin
            wait_req("drain_req");
            chk("drain_addr", out_mem_addr, 32'h1000 + 32'(k * 4));
            mem_done(32'h50 + 32'(k));
            chk("drain_cdb_tag", 32'(out_ls_cdb_rob_tag), 32'((k % 15) + 1));
            chk("drain_cdb_val", out_ls_cdb_value, 32'h50 + 32'(k));
            if (k == 0) begin
                chk("drain_not_full", 32'(out_lsq_full), 32'd0);
                enq(1'b0, F3_W, 32'h400, 4'd0, 32'h1000, 4'd0, 32'd0, 4'd12);
            end
        end
        wait_req("wrap_req");
        chk("wrap_addr", out_mem_addr, 32'h1400);
        mem_done(32'h77);
        chk("wrap_cdb_tag", 32'(out_ls_cdb_rob_tag), 32'd12);
        tick(); tick(); tick();
        chk("drain_empty", 32'(out_mem_req), 32'd0);

        // two committed stores + three speculative loads, then misbranch
        enq(1'b1, F3_W, 32'd0, 4'd0, 32'h300, 4'd0, 32'h11, 4'd1);
        enq(1'b1, F3_W, 32'd0, 4'd0, 32'h304, 4'd0, 32'h22, 4'd2);
        enq(1'b0, F3_W, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 4'd3);
        enq(1'b0, F3_W, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 4'd4);
        enq(1'b0, F3_W, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 4'd5);
        in_committed_rob_tag = 4'd1;
        tick();
        in_committed_rob_tag = 4'd2;
        tick();
        in_committed_rob_tag = 4'd0; in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        chk("mb_st1_req", 32'(out_mem_req), 32'd1);
        chk("mb_st1_addr", out_mem_addr, 32'h300);
        chk("mb_st1_wdata", out_mem_wdata, 32'h11);
        mem_done(32'd0);
        wait_req("mb_st2_req");
        chk("mb_st2_we", 32'(out_mem_we), 32'd1);
        chk("mb_st2_addr", out_mem_addr, 32'h304);
        chk("mb_st2_wdata", out_mem_wdata, 32'h22);
        mem_done(32'd0);
        in_cdb_rob_tag = 4'd9; in_cdb_value = 32'h900;
        tick();
        in_cdb_rob_tag = 4'd0; in_cdb_value = '0;
        hits = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_mem_req || out_ls_cdb_rob_tag != 4'd0) hits++;
            tick();
        end
        chk("mb_loads_gone", 32'(hits), 32'd0);

        // misbranch while a load is outstanding
        enq(1'b0, F3_W, 32'd0, 4'd0, 32'h500, 4'd0, 32'd0, 4'd4);
        wait_req("mbw_req");
        chk("mbw_addr", out_mem_addr, 32'h500);
        in_misbranch = 1'b1;
        tick();
        in_misbranch = 1'b0;
        tick();
        chk("mbw_req_held", 32'(out_mem_req), 32'd1);
        mem_done(32'h1234);
        chk("mbw_no_bcast", 32'(out_ls_cdb_rob_tag), 32'd0);
        chk("mbw_req_drop", 32'(out_mem_req), 32'd0);
        hits = 0;
        for (int c = 0; c < 4; c++) begin
            if (out_mem_req || out_ls_cdb_rob_tag != 4'd0) hits++;
            tick();
        end
        chk("mbw_empty", 32'(hits), 32'd0);

        // reset during WAIT, then normal operation resumes
        enq(1'b0, F3_W, 32'd0, 4'd0, 32'h600, 4'd0, 32'd0, 4'd5);
        wait_req("rw_req");
        rst_n = 1'b0;
        #1;
        chk("rw_req_clr", 32'(out_mem_req), 32'd0);
        chk("rw_addr_clr", out_mem_addr, 32'd0);
        chk("rw_size_clr", 32'(out_mem_size), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        enq(1'b0, F3_BU, 32'd8, 4'd0, 32'h700, 4'd0, 32'd0, 4'd6);
        wait_req("rw_lbu_req");
        chk("rw_lbu_addr", out_mem_addr, 32'h708);
        chk("rw_lbu_size", 32'(out_mem_size), 32'd0);
        mem_done(32'hFF80);
        chk("rw_lbu_tag", 32'(out_ls_cdb_rob_tag), 32'd6);
        chk("rw_lbu_val", out_ls_cdb_value, 32'h80);

        // LH sign extension, with a stall while the request is outstanding
        enq(1'b0, F3_H, 32'd0, 4'd0, 32'h800, 4'd0, 32'd0, 4'd7);
        wait_req("lh_req");
        chk("lh_size", 32'(out_mem_size), 32'd1);
        ena = 1'b0;
        tick(); tick();
        chk("stall_req", 32'(out_mem_req), 32'd1);
        chk("stall_addr", out_mem_addr, 32'h800);
        ena = 1'b1;
        mem_done(32'h0000_8001);
        chk("lh_tag", 32'(out_ls_cdb_rob_tag), 32'd7);
        chk("lh_val", out_ls_cdb_value, 32'hFFFF_8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
